ahb_lite_master: RTL

//  AHB-Lite initiator that converts a simple request/response stream into single NONSEQ bus transfers.

---
 rtl/ahb_lite_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a request/response stream into single
// NONSEQ transfers with pipelined address and data phases.
module ahb_lite_master #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic              ap_valid;
  logic [ADDR_W-1:0] ap_addr;
  logic [1:0]        ap_size;
  logic              ap_write;
  logic [31:0]       ap_wdata;

  logic              dp_valid;
  logic              dp_write;
  logic [31:0]       dp_wdata;

  logic              err_blk;
  logic              ap_adv;
  logic              dp_done;
  logic              accept;
  logic [1:0]        size_in;

  // ERROR blocks the address phase in both response cycles
  assign err_blk = dp_valid && hresp;
  assign ap_adv  = ap_valid && hready && !err_blk;
  assign dp_done = dp_valid && hready;

  assign req_ready = !rst && (!ap_valid || ap_adv);
  assign accept    = req_valid && req_ready;

  assign size_in = (req_size == 2'd3) ? 2'd2 : req_size;

  assign htrans = (ap_valid && !err_blk) ? HT_NONSEQ : HT_IDLE;
  assign hsel   = (htrans == HT_NONSEQ);
  assign haddr  = ap_valid ? ap_addr  : '0;
  assign hsize  = ap_valid ? ap_size  : 2'd0;
  assign hwrite = ap_valid ? ap_write : 1'b0;
  assign hburst = 3'd0;
  assign hwdata = dp_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      ap_valid <= 1'b0;
      ap_addr  <= '0;
      ap_size  <= 2'd0;
      ap_write <= 1'b0;
      ap_wdata <= 32'd0;
    end else if (accept) begin
      ap_valid <= 1'b1;
      ap_addr  <= req_addr;
      ap_size  <= size_in;
      ap_write <= req_write;
      ap_wdata <= req_wdata;
    end else if (ap_adv) begin
      ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= 32'd0;
    end else if (ap_adv) begin
      dp_valid <= 1'b1;
      dp_write <= ap_write;
      dp_wdata <= ap_wdata;
    end else if (dp_done) begin
      dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= dp_done;
      if (dp_done) begin
        rsp_write <= dp_write;
        rsp_rdata <= dp_write ? 32'd0 : hrdata;
        rsp_error <= hresp;
      end
    end
  end

  // counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else if (dp_done) begin
      if (xfer_count != '1)
        xfer_count <= xfer_count + 1'b1;
      if (hresp && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule
